// File: rtl/mod_exp_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM states and the
// kind of product currently handed to the external reducer.
package mod_exp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_BASE,
        OP_SQR,
        OP_MUL
    } op_t;

endpackage

// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer: forms 2*WIDTH-bit products and
// hands each one to an external modular reducer over the red_* handshake.
module mod_exp_sequencer
    import mod_exp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   ready_in,
    input  logic [WIDTH-1:0]       base_in,
    input  logic [EXP_WIDTH-1:0]   exponent_in,
    input  logic [WIDTH-1:0]       modulus_in,
    output logic [WIDTH-1:0]       value_out,
    output logic                   busy_out,
    output logic                   valid_out,
    output logic                   red_ready_out,
    output logic [2*WIDTH-1:0]     red_value_out,
    output logic [WIDTH-1:0]       red_modulus_out,
    input  logic [WIDTH-1:0]       red_value_in,
    input  logic                   red_busy_in,
    input  logic                   red_valid_in
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(EXP_WIDTH - 1);

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     base_red_q, base_red_d;
    logic [WIDTH-1:0]     value_q, value_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 red_ready_q, red_ready_d;
    logic [PW-1:0]        red_value_q, red_value_d;
    logic [WIDTH-1:0]     red_mod_q, red_mod_d;
    logic [PW-1:0]        product;
    logic                 advance;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            op_q        <= OP_BASE;
            idx_q       <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            result_q    <= '0;
            base_red_q  <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            red_ready_q <= 1'b0;
            red_value_q <= '0;
            red_mod_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            base_red_q  <= base_red_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            red_ready_q <= red_ready_d;
            red_value_q <= red_value_d;
            red_mod_q   <= red_mod_d;
        end
    end

    // Full-width unsigned product; OP_BASE just zero-extends the base.
    always_comb begin
        product = PW'(base_q);
        case (op_q)
            OP_SQR:  product = PW'(result_q) * PW'(result_q);
            OP_MUL:  product = PW'(result_q) * PW'(base_red_q);
            default: product = PW'(base_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        base_d      = base_q;
        exp_d       = exp_q;
        result_d    = result_q;
        base_red_d  = base_red_q;
        value_d     = value_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        red_ready_d = 1'b0;
        red_value_d = red_value_q;
        red_mod_d   = red_mod_q;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready_in) begin
                    base_d    = base_in;
                    exp_d     = exponent_in;
                    red_mod_d = modulus_in;
                    result_d  = WIDTH'(1);
                    idx_d     = IDX_TOP;
                    op_d      = OP_BASE;
                    busy_d    = 1'b1;
                    if (modulus_in == '0) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!red_busy_in) begin
                    red_value_d = product;
                    red_ready_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (red_valid_in) begin
                    if (op_q == OP_BASE) begin
                        base_red_d = red_value_in;
                        op_d       = OP_SQR;
                        state_d    = ISSUE;
                    end else begin
                        result_d = red_value_in;
                        if (op_q == OP_SQR && exp_q[idx_q]) begin
                            op_d    = OP_MUL;
                            state_d = ISSUE;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    // The current exponent bit is finished; move to the next lower one.
                    if (advance) begin
                        if (idx_q == '0) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q - IW'(1);
                            op_d    = OP_SQR;
                            state_d = ISSUE;
                        end
                    end
                end
            end
            DONE: begin
                value_d = result_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign value_out       = value_q;
    assign busy_out        = busy_q;
    assign valid_out       = valid_q;
    assign red_ready_out   = red_ready_q;
    assign red_value_out   = red_value_q;
    assign red_modulus_out = red_mod_q;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Directed plus random bench for mod_exp_sequencer with a fixed-latency reducer
// model on the red_* ports and an arithmetic reference for base^exp mod m.
module tb_mod_exp_sequencer;

    localparam int W = 16;
    localparam int E = 16;
    localparam int L = 5;

    logic            clk_in;
    logic            rst_in;
    logic            ready_in;
    logic [W-1:0]    base_in;
    logic [E-1:0]    exponent_in;
    logic [W-1:0]    modulus_in;
    logic [W-1:0]    value_out;
    logic            busy_out;
    logic            valid_out;
    logic            red_ready_out;
    logic [2*W-1:0]  red_value_out;
    logic [W-1:0]    red_modulus_out;
    logic [W-1:0]    red_value_in;
    logic            red_busy_in;
    logic            red_valid_in;

    logic            model_valid;
    logic [W-1:0]    model_value;
    logic            stray_valid;
    bit              stall_mode;

    int checks;
    int fails;
    int pulses;
    logic [2*W-1:0] first_req;

    bit             pend;
    int             cnt;
    int             bcnt;
    logic [2*W-1:0] pend_val;
    logic [W-1:0]   pend_mod;
    logic [2*W-1:0] rem32;

    assign red_valid_in = model_valid | stray_valid;
    assign red_value_in = stray_valid ? 16'h1234 : model_value;

    mod_exp_sequencer #(.WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .ready_in        (ready_in),
        .base_in         (base_in),
        .exponent_in     (exponent_in),
        .modulus_in      (modulus_in),
        .value_out       (value_out),
        .busy_out        (busy_out),
        .valid_out       (valid_out),
        .red_ready_out   (red_ready_out),
        .red_value_out   (red_value_out),
        .red_modulus_out (red_modulus_out),
        .red_value_in    (red_value_in),
        .red_busy_in     (red_busy_in),
        .red_valid_in    (red_valid_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Square-and-multiply straight from the arithmetic definition.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [E-1:0] e,
                                                input logic [W-1:0] m);
        longint unsigned r, bb, mm;
        if (m == '0) return '0;
        mm = 64'(m);
        bb = 64'(b) % mm;
        r  = 64'd1 % mm;
        for (int i = E - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * bb) % mm;
        end
        return W'(r);
    endfunction

    // Fixed-latency reducer: result seen by the DUT L edges after the request edge.
    always @(negedge clk_in) begin
        model_valid = 1'b0;
        if (!rst_in) begin
            pend        = 1'b0;
            bcnt        = 0;
            red_busy_in = 1'b0;
        end else begin
            if (bcnt > 0) bcnt--;
            red_busy_in = (bcnt > 0);
            if (pend) begin
                check("red_value_stable", 64'(red_value_out), 64'(pend_val));
                if (cnt == 1) begin
                    rem32       = pend_val % {16'b0, pend_mod};
                    model_value = rem32[W-1:0];
                    model_valid = 1'b1;
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (red_ready_out) begin
                pulses++;
                if (pulses == 1) first_req = red_value_out;
                pend     = 1'b1;
                cnt      = L - 1;
                pend_val = red_value_out;
                pend_mod = red_modulus_out;
                if (stall_mode) begin
                    bcnt        = 7;
                    red_busy_in = 1'b1;
                end
            end
        end
    end

    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [E-1:0] e,
                          input logic [W-1:0] m, input bit stall, input bit hold);
        int cyc;
        int n;
        bit got;
        logic [W-1:0] expv;
        expv = ref_modexp(b, e, m);
        n    = (m == '0) ? 0 : 1 + E + $countones(e);
        @(negedge clk_in);
        base_in     = b;
        exponent_in = e;
        modulus_in  = m;
        ready_in    = 1'b1;
        stall_mode  = stall;
        pulses      = 0;
        @(posedge clk_in);
        cyc = 0;
        got = 1'b0;
        @(negedge clk_in);
        if (!hold) ready_in = 1'b0;
        check({tag, "_busy"}, 64'(busy_out), 64'(1));
        while (!got && cyc < 3000) begin
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
            if (valid_out) got = 1'b1;
        end
        ready_in = 1'b0;
        check({tag, "_done"}, 64'(got), 64'(1));
        check({tag, "_value"}, 64'(value_out), 64'(expv));
        check({tag, "_pulses"}, 64'(pulses), 64'(n));
        if (m == '0)
            check({tag, "_lat_zero_mod"}, 64'(cyc <= 2), 64'(1));
        else if (!stall)
            check({tag, "_latency"}, 64'(cyc), 64'(n * (L + 1) + 1));
        @(posedge clk_in);
        @(negedge clk_in);
        check({tag, "_valid_pulse"}, 64'(valid_out), 64'(0));
        check({tag, "_value_hold"}, 64'(value_out), 64'(expv));
        check({tag, "_idle_busy"}, 64'(busy_out), 64'(0));
        $display("op %s: %0d^%0d mod %0d -> %0d (expected %0d) in %0d cycles, %0d requests",
                 tag, b, e, m, value_out, expv, cyc, pulses);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; fails = 0; pulses = 0; first_req = '0;
        pend = 1'b0; cnt = 0; bcnt = 0; pend_val = '0; pend_mod = '0; rem32 = '0;
        rst_in = 1'b0; ready_in = 1'b0; base_in = '0; exponent_in = '0; modulus_in = '0;
        model_valid = 1'b0; model_value = '0; stray_valid = 1'b0; stall_mode = 1'b0;
        red_busy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_value", 64'(value_out), 64'(0));
        check("rst_busy", 64'(busy_out), 64'(0));
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_red_ready", 64'(red_ready_out), 64'(0));
        check("rst_red_value", 64'(red_value_out), 64'(0));
        check("rst_red_mod", 64'(red_modulus_out), 64'(0));
        rst_in = 1'b1;

        run_op("4_13_497", 16'd4, 16'd13, 16'd497, 1'b0, 1'b0);
        run_op("1000_2_497", 16'd1000, 16'd2, 16'd497, 1'b0, 1'b0);
        check("first_req_base", 64'(first_req), 64'(1000));
        run_op("2_16_65521", 16'd2, 16'd16, 16'd65521, 1'b0, 1'b0);
        run_op("exp0", 16'd7, 16'd0, 16'd497, 1'b0, 1'b0);
        run_op("mod1", 16'd9, 16'd5, 16'd1, 1'b0, 1'b0);
        run_op("mod0", 16'd9, 16'd5, 16'd0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rand%0d", i), W'($urandom), E'($urandom),
                   W'($urandom_range(1, 65535)), 1'b0, 1'b0);
        end

        run_op("stall_4_13", 16'd4, 16'd13, 16'd497, 1'b1, 1'b0);
        run_op("stall_rand", W'($urandom), E'($urandom), W'($urandom_range(2, 65535)), 1'b1, 1'b0);

        @(negedge clk_in);
        stray_valid = 1'b1;
        @(negedge clk_in);
        stray_valid = 1'b0;
        @(negedge clk_in);
        check("stray_busy", 64'(busy_out), 64'(0));
        check("stray_valid", 64'(valid_out), 64'(0));
        check("stray_red_ready", 64'(red_ready_out), 64'(0));
        $display("stray red_valid_in in IDLE: busy=%0d valid=%0d", busy_out, valid_out);
        run_op("after_stray", 16'd3, 16'd7, 16'd1000, 1'b0, 1'b0);

        run_op("hold_ready", 16'd4, 16'd13, 16'd497, 1'b0, 1'b1);

        @(negedge clk_in);
        base_in = 16'd4; exponent_in = 16'd13; modulus_in = 16'd497; ready_in = 1'b1;
        stall_mode = 1'b0;
        @(negedge clk_in);
        ready_in = 1'b0;
        repeat (30) @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check("midrst_value", 64'(value_out), 64'(0));
        check("midrst_busy", 64'(busy_out), 64'(0));
        check("midrst_valid", 64'(valid_out), 64'(0));
        check("midrst_red_ready", 64'(red_ready_out), 64'(0));
        check("midrst_red_value", 64'(red_value_out), 64'(0));
        check("midrst_red_mod", 64'(red_modulus_out), 64'(0));
        $display("mid-run reset: value=%0d busy=%0d red_value=%0d", value_out, busy_out, red_value_out);
        rst_in = 1'b1;
        repeat (10) @(negedge clk_in);
        run_op("after_rst", 16'd4, 16'd13, 16'd497, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
